johnson_monitor: RTL
====================

# johnson_monitor

Downstream consumer of the 4-bit Johnson counter output on the DE1-SoC. It samples the counter code in a faster clock domain and decodes it to a phase index. It flags illegal codes and out-of-sequence steps, and counts completed revolutions as a two-digit BCD value shown on two active-low seven-segment displays. Typical hookup: jc from the Johnson counter's LEDR output, clk from CLOCK_50 or a low clk[] tap, reset from KEY[0].

## Interface
Parameters:
- MAX_REVS, default 99: BCD revolution count wraps from MAX_REVS to 0. Legal range 1..99.

Ports:
- clk  in  1  sampling clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- jc  in  4  Johnson counter code, asynchronous to clk
- clear  in  1  synchronous clear of revs and err
- phase  out  3  decoded phase of last legal accepted code, 0..7
- valid  out  1  1 when the last accepted code is legal
- step  out  1  one-cycle pulse per legal forward step
- err  out  1  sticky error: illegal code, backward step or skipped phase
- revs  out  8  BCD revolutions: [7:4] tens, [3:0] ones
- hex0  out  7  active-low seven-segment for revs[3:0]
- hex1  out  7  active-low seven-segment for revs[7:4]

## Operation
- Synchronizer: two flops s1 -> s2 on jc, both reset to 0000. Johnson codes change one bit per step, so a two-flop sync yields either the old or new code, never a hybrid.
- Decode table, code -> phase: 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7. The other 8 codes are illegal.
- Registered state: last (4b, last accepted code), phase, valid, step, err, revs.
- Reset values: last=0000, phase=0, valid=1, step=0, err=0, revs=0x00, hex0=hex1=1000000 (digit 0).
- Each cycle, compare s2 to last:
  - s2 == last: no change; step=0.
  - s2 legal and decode(s2) == phase+1 mod 8: step=1, phase<=decode(s2), valid<=1, last<=s2.
  - s2 legal and not phase+1 (backward or skip): err<=1, phase<=decode(s2), valid<=1, last<=s2, step=0.
  - s2 illegal: err<=1, valid<=0, last<=s2, phase holds, step=0.
  - Leaving an illegal code for a legal one: phase<=decode(s2), valid<=1, no step, err stays 1.
- Revolution: a legal forward step from phase 7 to 0 increments revs in BCD. Ones 9 -> 0 carries into tens. revs == MAX_REVS wraps to 0x00.
- clear=1: revs<=0x00, err<=0 on the next edge. Phase, last, valid and the synchronizer are unaffected.
  - clear together with an increment: clear wins (revs=0x00); step still pulses.
  - clear together with a new error: err=1 (the error wins).
- Seven-segment: combinational from revs digits, active-low, segment order g..a = [6:0]. 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

## Timing
- Latency: a jc change captured at edge N appears in s2 after edge N+1. phase/valid/step/err/revs update at edge N+2, and hex follows combinationally in the same cycle.
- step is high for exactly one clk cycle per accepted forward step.
- jc must hold each code for at least 2 clk cycles. Faster changes can drop codes, and the resulting skip is reported as err.
- Reset asserted mid-operation returns every output to its reset value asynchronously. After release, the first differing s2 is evaluated against last=0000/phase 0.

## Test plan
- Reset then jc=0000 held: phase=0, valid=1, step=0, err=0, revs=0x00, hex0=hex1=1000000.
- Drive 0001, 0011, ..., 1000, 0000, each held 4 clks: 8 step pulses, each 3 edges after the jc change. phase runs 1..7,0; revs=0x01; hex0=1111001; err=0.
- 10 full revolutions: revs=0x10, hex1=1111001, hex0=1000000. With MAX_REVS=3, 4 revolutions give revs=0x00.
- From phase 2 (0011) drive 1111: err=1, phase=4, no step. Then drive 0101: valid=0, phase stays 4. Then 1110: valid=1, phase=5, no step.
- clear pulsed on the same cycle as the 7->0 step: step=1, revs=0x00, err=0. clear coinciding with an illegal code: err=1.
- Assert reset mid-sequence at phase 5, revs=0x23: all outputs return to reset values before the next clk edge.

Source files
------------

// File: rtl/johnson_monitor_if.sv
// Bundles the Johnson code input, the clear control and all monitor results.
// The monitor takes the slave view; the driver/observer takes the master view.
interface johnson_monitor_if;
    logic [3:0] jc;
    logic       clear;
    logic [2:0] phase;
    logic       valid;
    logic       step;
    logic       err;
    logic [7:0] revs;
    logic [6:0] hex0;
    logic [6:0] hex1;

    modport master (
        output jc, clear,
        input  phase, valid, step, err, revs, hex0, hex1
    );

    modport slave (
        input  jc, clear,
        output phase, valid, step, err, revs, hex0, hex1
    );
endinterface

// File: rtl/johnson_monitor.sv
// Johnson counter monitor: synchronizes a 4-bit Johnson code, decodes it to a
// phase, flags illegal/out-of-order codes, and counts revolutions in BCD with
// active-low seven-segment outputs for the two digits.
module johnson_monitor #(
    parameter int MAX_REVS = 99
) (
    input  logic                 clk,
    input  logic                 reset,
    johnson_monitor_if.slave     bus
);

    localparam logic [3:0] MAX_TENS = 4'(MAX_REVS / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_REVS % 10);

    logic [3:0] s1_q, s1_d;
    logic [3:0] s2_q, s2_d;
    logic [3:0] last_q, last_d;
    logic [2:0] phase_q, phase_d;
    logic       valid_q, valid_d;
    logic       step_q, step_d;
    logic       err_q, err_d;
    logic [7:0] revs_q, revs_d;

    logic       dec_legal;
    logic [2:0] dec_phase;
    logic       err_set;
    logic       rev_inc;
    logic [7:0] revs_inc_val;

    // Returns {legal, phase} for a Johnson code.
    function automatic logic [3:0] decode(input logic [3:0] code);
        logic [3:0] r;
        case (code)
            4'b0000: r = {1'b1, 3'd0};
            4'b0001: r = {1'b1, 3'd1};
            4'b0011: r = {1'b1, 3'd2};
            4'b0111: r = {1'b1, 3'd3};
            4'b1111: r = {1'b1, 3'd4};
            4'b1110: r = {1'b1, 3'd5};
            4'b1100: r = {1'b1, 3'd6};
            4'b1000: r = {1'b1, 3'd7};
            default: r = {1'b0, 3'd0};
        endcase
        return r;
    endfunction

    // Active-low seven-segment pattern, bit order g..a.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] s;
        case (digit)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Next-state: synchronizer shift, code comparison, error and BCD revolution logic.
    always_comb begin
        s1_d    = bus.jc;
        s2_d    = s1_q;
        last_d  = last_q;
        phase_d = phase_q;
        valid_d = valid_q;
        step_d  = 1'b0;
        err_set = 1'b0;
        rev_inc = 1'b0;
        {dec_legal, dec_phase} = decode(s2_q);

        if (s2_q != last_q) begin
            last_d = s2_q;
            if (dec_legal) begin
                phase_d = dec_phase;
                valid_d = 1'b1;
                if (!valid_q) begin
                    // Recovering from an illegal code: resync without a step.
                    // The error raised on entry to the illegal code remains.
                    step_d = 1'b0;
                end else if (dec_phase == 3'(phase_q + 3'd1)) begin
                    step_d  = 1'b1;
                    rev_inc = (phase_q == 3'd7);
                end else begin
                    err_set = 1'b1;
                end
            end else begin
                valid_d = 1'b0;
                err_set = 1'b1;
            end
        end

        // A fresh error beats clear; otherwise clear drops the sticky flag.
        err_d = err_set | (err_q & ~bus.clear);

        if (revs_q == {MAX_TENS, MAX_ONES}) begin
            revs_inc_val = 8'h00;
        end else if (revs_q[3:0] == 4'd9) begin
            revs_inc_val = {4'(revs_q[7:4] + 4'd1), 4'd0};
        end else begin
            revs_inc_val = {revs_q[7:4], 4'(revs_q[3:0] + 4'd1)};
        end

        if (bus.clear) begin
            revs_d = 8'h00;
        end else if (rev_inc) begin
            revs_d = revs_inc_val;
        end else begin
            revs_d = revs_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= 4'b0000;
            s2_q    <= 4'b0000;
            last_q  <= 4'b0000;
            phase_q <= 3'd0;
            valid_q <= 1'b1;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            revs_q  <= 8'h00;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            last_q  <= last_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            err_q   <= err_d;
            revs_q  <= revs_d;
        end
    end

    assign bus.phase = phase_q;
    assign bus.valid = valid_q;
    assign bus.step  = step_q;
    assign bus.err   = err_q;
    assign bus.revs  = revs_q;
    assign bus.hex0  = seg7(revs_q[3:0]);
    assign bus.hex1  = seg7(revs_q[7:4]);

endmodule
